instruction_decode: RTL and testbench

//  ID stage of the 5-stage RV32I pipeline; consumes IF_ID_pc/IF_ID_inst from fetch.

---
 rtl/instruction_decode_pkg.sv | 55 +++++
 rtl/instruction_decode_if.sv | 72 +++++++
 rtl/instruction_decode_register_file.sv | 59 +++++
 rtl/instruction_decode.sv | 256 +++++++++++++++++++++++++
 tb/tb_instruction_decode.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_decode_pkg
//  Description : Shared RV32I decode constants, ALU operation enum and the
//                ID/EX control bundle used by the instruction decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package instruction_decode_pkg;

    // Major opcodes handled by the decoder
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;

    // funct3 values
    localparam logic [2:0] c_f3_add_sub = 3'b000;
    localparam logic [2:0] c_f3_and     = 3'b111;
    localparam logic [2:0] c_f3_or      = 3'b110;
    localparam logic [2:0] c_f3_word    = 3'b010;
    localparam logic [2:0] c_f3_beq     = 3'b000;

    // funct7 values
    localparam logic [6:0] c_f7_base = 7'b0000000;
    localparam logic [6:0] c_f7_alt  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3
    } alu_op_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    alu_src;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
        logic    mem_to_reg;
    } id_ex_ctrl_t;

    // All-zero control word: what a bubble carries into EX
    localparam id_ex_ctrl_t c_ctrl_bubble = '{
        alu_op:     ALU_ADD,
        alu_src:    1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        reg_write:  1'b0,
        mem_to_reg: 1'b0
    };

endpackage
`default_nettype wire

// File: rtl/instruction_decode_if.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_decode_if
//  Description : Bundle of fetch, writeback, EX/MEM and ID/EX signals seen by
//                the instruction decode stage. The slave modport is the ID
//                stage; the master modport is the surrounding pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instruction_decode_if #(
    parameter int XLEN = 32
);
    import instruction_decode_pkg::*;

    // From fetch
    logic [XLEN-1:0] IF_ID_pc;
    logic [31:0]     IF_ID_inst;
    // From writeback
    logic            wb_reg_write;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    // From EX/MEM
    logic            ex_mem_reg_write;
    logic            ex_mem_mem_read;
    logic [4:0]      ex_mem_rd;
    logic [XLEN-1:0] ex_mem_alu_result;
    // To fetch
    logic            pc_write;
    logic            IF_ID_write;
    logic            branch;
    logic            br_eq;
    logic            pc_src;
    logic            IF_flush;
    logic [XLEN-1:0] pc_branch;
    // ID/EX register
    logic [XLEN-1:0] ID_EX_pc;
    logic [XLEN-1:0] ID_EX_rs1_data;
    logic [XLEN-1:0] ID_EX_rs2_data;
    logic [XLEN-1:0] ID_EX_imm;
    logic [4:0]      ID_EX_rs1;
    logic [4:0]      ID_EX_rs2;
    logic [4:0]      ID_EX_rd;
    alu_op_e         ID_EX_alu_op;
    logic            ID_EX_alu_src;
    logic            ID_EX_mem_read;
    logic            ID_EX_mem_write;
    logic            ID_EX_reg_write;
    logic            ID_EX_mem_to_reg;

    modport master (
        output IF_ID_pc, IF_ID_inst,
        output wb_reg_write, wb_rd, wb_data,
        output ex_mem_reg_write, ex_mem_mem_read, ex_mem_rd, ex_mem_alu_result,
        input  pc_write, IF_ID_write, branch, br_eq, pc_src, IF_flush, pc_branch,
        input  ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm,
        input  ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_alu_op,
        input  ID_EX_alu_src, ID_EX_mem_read, ID_EX_mem_write,
        input  ID_EX_reg_write, ID_EX_mem_to_reg
    );

    modport slave (
        input  IF_ID_pc, IF_ID_inst,
        input  wb_reg_write, wb_rd, wb_data,
        input  ex_mem_reg_write, ex_mem_mem_read, ex_mem_rd, ex_mem_alu_result,
        output pc_write, IF_ID_write, branch, br_eq, pc_src, IF_flush, pc_branch,
        output ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm,
        output ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_alu_op,
        output ID_EX_alu_src, ID_EX_mem_read, ID_EX_mem_write,
        output ID_EX_reg_write, ID_EX_mem_to_reg
    );

endinterface
`default_nettype wire

// File: rtl/instruction_decode_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : register_file
//  Description : 2-read / 1-write architectural register file. x0 always
//                reads zero; a same-cycle writeback to the addressed register
//                is bypassed to the read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    input  wire logic            we_i,
    input  wire logic [AW-1:0]   waddr_i,
    input  wire logic [XLEN-1:0] wdata_i,
    input  wire logic [AW-1:0]   raddr1_i,
    input  wire logic [AW-1:0]   raddr2_i,
    output logic      [XLEN-1:0] rdata1_o,
    output logic      [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] regs_q [NREG];

    // Storage: whole array cleared by reset, x0 never written
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Read port 1 with x0 masking and writeback bypass
    always_comb begin
        rdata1_o = regs_q[raddr1_i];
        if (raddr1_i == '0) begin
            rdata1_o = '0;
        end else if (we_i && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
    end

    // Read port 2 with x0 masking and writeback bypass
    always_comb begin
        rdata2_o = regs_q[raddr2_i];
        if (raddr2_i == '0) begin
            rdata2_o = '0;
        end else if (we_i && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instruction_decode.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_decode
//  Description : ID stage of a 5-stage RV32I pipeline. Decodes the fetched
//                instruction, reads the register file, detects load-use and
//                branch hazards, resolves beq and loads the ID/EX register.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_decode
    import instruction_decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  wire logic           clk,
    input  wire logic           reset_n,
    instruction_decode_if.slave bus
);

    // Instruction fields
    logic [6:0] w_opcode;
    logic [4:0] w_rd;
    logic [2:0] w_funct3;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [6:0] w_funct7;

    assign w_opcode = bus.IF_ID_inst[6:0];
    assign w_rd     = bus.IF_ID_inst[11:7];
    assign w_funct3 = bus.IF_ID_inst[14:12];
    assign w_rs1    = bus.IF_ID_inst[19:15];
    assign w_rs2    = bus.IF_ID_inst[24:20];
    assign w_funct7 = bus.IF_ID_inst[31:25];

    // Sign-extended immediates
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;

    assign w_imm_i = {{(XLEN-12){bus.IF_ID_inst[31]}}, bus.IF_ID_inst[31:20]};
    assign w_imm_s = {{(XLEN-12){bus.IF_ID_inst[31]}}, bus.IF_ID_inst[31:25],
                      bus.IF_ID_inst[11:7]};
    assign w_imm_b = {{(XLEN-13){bus.IF_ID_inst[31]}}, bus.IF_ID_inst[31],
                      bus.IF_ID_inst[7], bus.IF_ID_inst[30:25],
                      bus.IF_ID_inst[11:8], 1'b0};

    // Decoder outputs
    id_ex_ctrl_t     w_ctrl;
    logic            w_branch;
    logic            w_uses_rs2;
    logic [XLEN-1:0] w_imm;

    // ID/EX register state
    logic [XLEN-1:0] pc_q,  pc_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;
    logic [4:0]      rd_q,  rd_d;
    id_ex_ctrl_t     ctrl_q, ctrl_d;

    // Register file read data
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    // Hazard / branch signals
    logic            w_load_use;
    logic            w_br_hit1;
    logic            w_br_hit2;
    logic            w_br_hazard;
    logic            w_stall;
    logic            w_issue;
    logic [XLEN-1:0] w_cmp_op1;
    logic [XLEN-1:0] w_cmp_op2;
    logic            w_br_eq;
    logic            w_pc_src;

    // Control decode; anything unrecognised leaves the bubble defaults
    always_comb begin
        w_ctrl     = c_ctrl_bubble;
        w_branch   = 1'b0;
        w_uses_rs2 = 1'b0;
        w_imm      = '0;
        case (w_opcode)
            c_op_rtype: begin
                w_uses_rs2 = 1'b1;
                if (w_funct3 == c_f3_add_sub && w_funct7 == c_f7_base) begin
                    w_ctrl.reg_write = 1'b1;
                    w_ctrl.alu_op    = ALU_ADD;
                end else if (w_funct3 == c_f3_add_sub && w_funct7 == c_f7_alt) begin
                    w_ctrl.reg_write = 1'b1;
                    w_ctrl.alu_op    = ALU_SUB;
                end else if (w_funct3 == c_f3_and && w_funct7 == c_f7_base) begin
                    w_ctrl.reg_write = 1'b1;
                    w_ctrl.alu_op    = ALU_AND;
                end else if (w_funct3 == c_f3_or && w_funct7 == c_f7_base) begin
                    w_ctrl.reg_write = 1'b1;
                    w_ctrl.alu_op    = ALU_OR;
                end
            end
            c_op_itype: begin
                if (w_funct3 == c_f3_add_sub) begin
                    w_ctrl.reg_write = 1'b1;
                    w_ctrl.alu_src   = 1'b1;
                    w_imm            = w_imm_i;
                end
            end
            c_op_load: begin
                if (w_funct3 == c_f3_word) begin
                    w_ctrl.mem_read   = 1'b1;
                    w_ctrl.reg_write  = 1'b1;
                    w_ctrl.mem_to_reg = 1'b1;
                    w_ctrl.alu_src    = 1'b1;
                    w_imm             = w_imm_i;
                end
            end
            c_op_store: begin
                w_uses_rs2 = 1'b1;
                if (w_funct3 == c_f3_word) begin
                    w_ctrl.mem_write = 1'b1;
                    w_ctrl.alu_src   = 1'b1;
                    w_imm            = w_imm_s;
                end
            end
            c_op_branch: begin
                w_uses_rs2 = 1'b1;
                if (w_funct3 == c_f3_beq) begin
                    w_branch = 1'b1;
                end
            end
            default: ;
        endcase
    end

    register_file #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_register_file (
        .clk      (clk),
        .reset_n  (reset_n),
        .we_i     (bus.wb_reg_write),
        .waddr_i  (bus.wb_rd),
        .wdata_i  (bus.wb_data),
        .raddr1_i (w_rs1),
        .raddr2_i (w_rs2),
        .rdata1_o (w_rs1_data),
        .rdata2_o (w_rs2_data)
    );

    // Hazard detection: load-use against ID/EX, branch sources against EX and EX/MEM
    always_comb begin
        w_load_use  = ctrl_q.mem_read && (rd_q != 5'd0) &&
                      ((rd_q == w_rs1) || (w_uses_rs2 && (rd_q == w_rs2)));
        w_br_hit1   = (w_rs1 != 5'd0) &&
                      ((ctrl_q.reg_write && (rd_q == w_rs1)) ||
                       (bus.ex_mem_mem_read && (bus.ex_mem_rd == w_rs1)));
        w_br_hit2   = (w_rs2 != 5'd0) &&
                      ((ctrl_q.reg_write && (rd_q == w_rs2)) ||
                       (bus.ex_mem_mem_read && (bus.ex_mem_rd == w_rs2)));
        w_br_hazard = w_branch && (w_br_hit1 || w_br_hit2);
        w_stall     = w_load_use || w_br_hazard;
    end

    // Branch compare with EX/MEM ALU-result forwarding
    always_comb begin
        w_cmp_op1 = w_rs1_data;
        w_cmp_op2 = w_rs2_data;
        if (bus.ex_mem_reg_write && !bus.ex_mem_mem_read &&
            (bus.ex_mem_rd == w_rs1) && (w_rs1 != 5'd0)) begin
            w_cmp_op1 = bus.ex_mem_alu_result;
        end
        if (bus.ex_mem_reg_write && !bus.ex_mem_mem_read &&
            (bus.ex_mem_rd == w_rs2) && (w_rs2 != 5'd0)) begin
            w_cmp_op2 = bus.ex_mem_alu_result;
        end
        w_br_eq  = (w_cmp_op1 == w_cmp_op2);
        w_pc_src = w_branch && w_br_eq && !w_stall;
    end

    // beq and illegal encodings carry no work into EX, nor does a stalled cycle
    assign w_issue = (w_ctrl.reg_write || w_ctrl.mem_write) && !w_stall;

    // ID/EX next state: decoded fields, or an all-zero bubble
    always_comb begin
        pc_d       = '0;
        rs1_data_d = '0;
        rs2_data_d = '0;
        imm_d      = '0;
        rs1_d      = '0;
        rs2_d      = '0;
        rd_d       = '0;
        ctrl_d     = c_ctrl_bubble;
        if (w_issue) begin
            pc_d       = bus.IF_ID_pc;
            rs1_data_d = w_rs1_data;
            rs1_d      = w_rs1;
            imm_d      = w_imm;
            ctrl_d     = w_ctrl;
            rd_d       = w_ctrl.reg_write ? w_rd : 5'd0;
            if (w_uses_rs2) begin
                rs2_data_d = w_rs2_data;
                rs2_d      = w_rs2;
            end
        end
    end

    // ID/EX pipeline register, reloaded every cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            ctrl_q     <= c_ctrl_bubble;
        end else begin
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            ctrl_q     <= ctrl_d;
        end
    end

    // Fetch control
    assign bus.pc_write    = !w_stall;
    assign bus.IF_ID_write = !w_stall;
    assign bus.branch      = w_branch;
    assign bus.br_eq       = w_br_eq;
    assign bus.pc_src      = w_pc_src;
    assign bus.IF_flush    = w_pc_src;
    assign bus.pc_branch   = bus.IF_ID_pc + w_imm_b;

    // ID/EX outputs
    assign bus.ID_EX_pc         = pc_q;
    assign bus.ID_EX_rs1_data   = rs1_data_q;
    assign bus.ID_EX_rs2_data   = rs2_data_q;
    assign bus.ID_EX_imm        = imm_q;
    assign bus.ID_EX_rs1        = rs1_q;
    assign bus.ID_EX_rs2        = rs2_q;
    assign bus.ID_EX_rd         = rd_q;
    assign bus.ID_EX_alu_op     = ctrl_q.alu_op;
    assign bus.ID_EX_alu_src    = ctrl_q.alu_src;
    assign bus.ID_EX_mem_read   = ctrl_q.mem_read;
    assign bus.ID_EX_mem_write  = ctrl_q.mem_write;
    assign bus.ID_EX_reg_write  = ctrl_q.reg_write;
    assign bus.ID_EX_mem_to_reg = ctrl_q.mem_to_reg;

endmodule
`default_nettype wire

// File: tb/tb_instruction_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_decode
//  Description : Directed self-checking bench for the instruction decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_decode;
    import instruction_decode_pkg::*;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    instruction_decode_if #(.XLEN(32)) bus ();

    instruction_decode #(
        .XLEN (32),
        .NREG (32)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, got timeout, need finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.IF_ID_pc          = '0;
        bus.IF_ID_inst        = '0;
        bus.wb_reg_write      = 1'b0;
        bus.wb_rd             = '0;
        bus.wb_data           = '0;
        bus.ex_mem_reg_write  = 1'b0;
        bus.ex_mem_mem_read   = 1'b0;
        bus.ex_mem_rd         = '0;
        bus.ex_mem_alu_result = '0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clear_inputs();
        reset_n = 1'b0;
        tick();
        tick();

        // Reset state
        check_eq("rst_pc",        bus.ID_EX_pc, 32'h0);
        check_eq("rst_rs1_data",  bus.ID_EX_rs1_data, 32'h0);
        check_eq("rst_imm",       bus.ID_EX_imm, 32'h0);
        check_eq("rst_rd",        bus.ID_EX_rd, 32'h0);
        check_eq("rst_ctrl",      {bus.ID_EX_alu_op, bus.ID_EX_alu_src, bus.ID_EX_mem_read,
                                   bus.ID_EX_mem_write, bus.ID_EX_reg_write, bus.ID_EX_mem_to_reg}, 32'h0);
        check_eq("rst_pc_write",  bus.pc_write, 32'h1);
        check_eq("rst_ifid_write", bus.IF_ID_write, 32'h1);
        check_eq("rst_pc_src",    bus.pc_src, 32'h0);
        reset_n = 1'b1;

        // Preload x1 = 0x100
        bus.wb_reg_write = 1'b1;
        bus.wb_rd        = 5'd1;
        bus.wb_data      = 32'h100;
        tick();

        // add x10,x5,x1 with WB x5=0x11 in the same cycle
        bus.wb_rd      = 5'd5;
        bus.wb_data    = 32'h11;
        bus.IF_ID_pc   = 32'h10;
        bus.IF_ID_inst = 32'h0012_8533;
        tick();
        check_eq("add_pc",       bus.ID_EX_pc, 32'h10);
        check_eq("add_rs1_data", bus.ID_EX_rs1_data, 32'h11);
        check_eq("add_rs2_data", bus.ID_EX_rs2_data, 32'h100);
        check_eq("add_rd",       bus.ID_EX_rd, 32'd10);
        check_eq("add_alu_op",   bus.ID_EX_alu_op, ALU_ADD);
        check_eq("add_reg_write", bus.ID_EX_reg_write, 32'h1);
        check_eq("add_alu_src",  bus.ID_EX_alu_src, 32'h0);
        bus.wb_reg_write = 1'b0;

        // lw x20,10(x2)
        bus.IF_ID_inst = 32'h00A1_2A03;
        tick();
        check_eq("lw_mem_read",  bus.ID_EX_mem_read, 32'h1);
        check_eq("lw_rd",        bus.ID_EX_rd, 32'd20);
        check_eq("lw_imm",       bus.ID_EX_imm, 32'd10);
        check_eq("lw_mem_to_reg", bus.ID_EX_mem_to_reg, 32'h1);

        // sub x12,x20,x8 -> one stall cycle
        bus.IF_ID_inst = 32'h408A_0633;
        #1;
        check_eq("lu_pc_write",  bus.pc_write, 32'h0);
        check_eq("lu_ifid_write", bus.IF_ID_write, 32'h0);
        tick();
        check_eq("lu_bubble_rw", bus.ID_EX_reg_write, 32'h0);
        check_eq("lu_bubble_rd", bus.ID_EX_rd, 32'h0);
        check_eq("lu_release",   bus.pc_write, 32'h1);
        tick();
        check_eq("sub_rd",       bus.ID_EX_rd, 32'd12);
        check_eq("sub_alu_op",   bus.ID_EX_alu_op, ALU_SUB);
        check_eq("sub_reg_write", bus.ID_EX_reg_write, 32'h1);
        check_eq("sub_rs2",      bus.ID_EX_rs2, 32'd8);

        // beq x6,x6,8 at 0x20
        bus.IF_ID_pc   = 32'h20;
        bus.IF_ID_inst = 32'h0063_0463;
        #1;
        check_eq("beq_branch",   bus.branch, 32'h1);
        check_eq("beq_br_eq",    bus.br_eq, 32'h1);
        check_eq("beq_pc_src",   bus.pc_src, 32'h1);
        check_eq("beq_flush",    bus.IF_flush, 32'h1);
        check_eq("beq_target",   bus.pc_branch, 32'h28);
        tick();
        check_eq("beq_bubble",   bus.ID_EX_reg_write, 32'h0);

        // sw x5,20(x2)
        bus.IF_ID_inst = 32'h0051_2A23;
        tick();
        check_eq("sw_mem_write", bus.ID_EX_mem_write, 32'h1);
        check_eq("sw_imm",       bus.ID_EX_imm, 32'd20);
        check_eq("sw_rs2_data",  bus.ID_EX_rs2_data, 32'h11);
        check_eq("sw_reg_write", bus.ID_EX_reg_write, 32'h0);

        // addi x15,x1,-50 with WB to x0
        bus.wb_reg_write = 1'b1;
        bus.wb_rd        = 5'd0;
        bus.wb_data      = 32'hFF;
        bus.IF_ID_inst   = 32'hFCE0_8793;
        tick();
        check_eq("addi_imm",     bus.ID_EX_imm, 32'hFFFF_FFCE);
        check_eq("addi_alu_src", bus.ID_EX_alu_src, 32'h1);
        check_eq("addi_rd",      bus.ID_EX_rd, 32'd15);
        check_eq("addi_rs1_data", bus.ID_EX_rs1_data, 32'h100);
        bus.wb_reg_write = 1'b0;

        // beq x15,x1,16 right behind addi x15 -> branch hazard
        bus.IF_ID_pc   = 32'h40;
        bus.IF_ID_inst = 32'h0017_8863;
        #1;
        check_eq("bh_pc_write",  bus.pc_write, 32'h0);
        check_eq("bh_pc_src",    bus.pc_src, 32'h0);
        tick();
        check_eq("bh_bubble",    bus.ID_EX_reg_write, 32'h0);
        check_eq("bh_release",   bus.pc_write, 32'h1);
        check_eq("bh_br_eq",     bus.br_eq, 32'h0);
        check_eq("bh_target",    bus.pc_branch, 32'h50);
        tick();

        // beq x7,x1,16 with x7 forwarded from EX/MEM
        bus.IF_ID_inst        = 32'h0013_8863;
        bus.ex_mem_reg_write  = 1'b1;
        bus.ex_mem_rd         = 5'd7;
        bus.ex_mem_alu_result = 32'h100;
        #1;
        check_eq("fwd_br_eq",    bus.br_eq, 32'h1);
        check_eq("fwd_pc_src",   bus.pc_src, 32'h1);
        bus.ex_mem_mem_read = 1'b1;
        #1;
        check_eq("exld_pc_src",  bus.pc_src, 32'h0);
        check_eq("exld_ifid_write", bus.IF_ID_write, 32'h0);
        bus.ex_mem_reg_write  = 1'b0;
        bus.ex_mem_mem_read   = 1'b0;
        bus.ex_mem_rd         = 5'd0;
        bus.ex_mem_alu_result = 32'h0;
        tick();

        // beq x0,x0,-8 at 0x4 -> target wraps
        bus.IF_ID_pc   = 32'h4;
        bus.IF_ID_inst = 32'hFE00_0CE3;
        #1;
        check_eq("wrap_target",  bus.pc_branch, 32'hFFFF_FFFC);
        check_eq("wrap_pc_src",  bus.pc_src, 32'h1);
        tick();

        // add x11,x0,x0 while WB targets x0
        bus.wb_reg_write = 1'b1;
        bus.wb_rd        = 5'd0;
        bus.wb_data      = 32'hFF;
        bus.IF_ID_pc     = 32'h60;
        bus.IF_ID_inst   = 32'h0000_05B3;
        tick();
        check_eq("x0_rs1_data",  bus.ID_EX_rs1_data, 32'h0);
        check_eq("x0_rd",        bus.ID_EX_rd, 32'd11);
        bus.wb_reg_write = 1'b0;

        // Asynchronous reset mid-cycle
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("midrst_rd",    bus.ID_EX_rd, 32'h0);
        check_eq("midrst_rw",    bus.ID_EX_reg_write, 32'h0);
        tick();
        reset_n = 1'b1;

        // Illegal instruction
        bus.IF_ID_inst = 32'hFFFF_FFFF;
        #1;
        check_eq("ill_pc_write", bus.pc_write, 32'h1);
        check_eq("ill_pc_src",   bus.pc_src, 32'h0);
        check_eq("ill_branch",   bus.branch, 32'h0);
        tick();
        check_eq("ill_ctrl",     {bus.ID_EX_alu_op, bus.ID_EX_alu_src, bus.ID_EX_mem_read,
                                  bus.ID_EX_mem_write, bus.ID_EX_reg_write, bus.ID_EX_mem_to_reg}, 32'h0);
        check_eq("ill_rd",       bus.ID_EX_rd, 32'h0);

        // add x12,x1,x5 -> regfile was cleared by the reset
        bus.IF_ID_inst = 32'h0050_8633;
        tick();
        check_eq("clr_rs1_data", bus.ID_EX_rs1_data, 32'h0);
        check_eq("clr_rs2_data", bus.ID_EX_rs2_data, 32'h0);
        check_eq("clr_reg_write", bus.ID_EX_reg_write, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
